hs32_bus_arb: RTL and testbench

- N-master, single-slave memory bus arbiter for the HS32 SoC.
- Generalises the single CPU/Wishbone bus-hold mux into a parametrised arbiter with:
  - per-master request buffering,
  - fixed or round-robin priority,
  - a forced-owner override (debug/LA hold),
  - a slave-ack timeout with error reporting.
- Sits between the masters (CPU core, Wishbone bridge, future DMA) and the mmio unit. Drives the SRAM chip-enable.

---
 rtl/hs32_bus_arb.sv | 189 ++++++++++++++++++
 tb/tb_hs32_bus_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_bus_arb.sv
// hs32_bus_arb: N-master, single-slave HS32 memory bus arbiter.
// Each master gets one buffered request slot. Arbitration is fixed priority or
// round-robin, with a forced-owner override and an optional slave-ack timeout.

// One buffered request per master. It holds until the arbiter takes it.
module hs32_arb_slot #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stb,
  input  logic          own,
  input  logic          take,
  input  logic          rw_in,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] dtw_in,
  output logic          pending,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dtw
);
  // Load on strobe unless already holding or owning the bus; a grant clears the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      rw      <= 1'b0;
      addr    <= '0;
      dtw     <= '0;
    end else if (take) begin
      pending <= 1'b0;
    end else if (stb && !pending && !own) begin
      pending <= 1'b1;
      rw      <= rw_in;
      addr    <= addr_in;
      dtw     <= dtw_in;
    end
  end
endmodule

module hs32_bus_arb #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NM-1:0]          m_stb,
  input  logic [NM-1:0]          m_rw,
  input  logic [NM*AW-1:0]       m_addr,
  input  logic [NM*DW-1:0]       m_dtw,
  output logic [NM-1:0]          m_ack,
  output logic [NM-1:0]          m_err,
  output logic [DW-1:0]          m_dtr,
  input  logic                   force_en,
  input  logic [$clog2(NM)-1:0]  force_sel,
  output logic                   s_stb,
  output logic                   s_rw,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_dtw,
  input  logic [DW-1:0]          s_dtr,
  input  logic                   s_ack,
  output logic [NM-1:0]          grant,
  output logic                   busy,
  output logic                   ram_ce
);
  localparam int IW = $clog2(NM);
  // The counter only ever holds 0..TIMEOUT-1
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  logic [NM-1:0]         pend, elig, own, take, slot_rw;
  logic [NM-1:0][AW-1:0] slot_addr;
  logic [NM-1:0][DW-1:0] slot_dtw;
  logic [IW-1:0]         ptr, win;
  logic                  any, start, acking, tmo;
  logic                  sel_rw;
  logic [AW-1:0]         sel_addr;
  logic [DW-1:0]         sel_dtw;
  logic [CW-1:0]         cnt;

  // Round-robin search order: k-th candidate after the last winner
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % NM);
  endfunction

  for (genvar i = 0; i < NM; i++) begin : g_slot
    assign own[i]  = (state == BUSY) && grant[i];
    assign take[i] = start && (win == IW'(i));
    hs32_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .stb     (m_stb[i]),
      .own     (own[i]),
      .take    (take[i]),
      .rw_in   (m_rw[i]),
      .addr_in (m_addr[i*AW +: AW]),
      .dtw_in  (m_dtw[i*DW +: DW]),
      .pending (pend[i]),
      .rw      (slot_rw[i]),
      .addr    (slot_addr[i]),
      .dtw     (slot_dtw[i])
    );
  end

  // Pick the winner among eligible masters; a live strobe competes like a pending one
  always_comb begin
    elig = '0;
    win  = '0;
    any  = 1'b0;
    for (int i = 0; i < NM; i++)
      elig[i] = (pend[i] | m_stb[i]) & (!force_en | (force_sel == IW'(i)));
    if (MODE == 0) begin
      for (int i = NM - 1; i >= 0; i--)
        if (elig[i]) begin
          win = IW'(i);
          any = 1'b1;
        end
    end else begin
      for (int k = NM; k >= 1; k--)
        if (elig[rr_idx(ptr, k)]) begin
          win = rr_idx(ptr, k);
          any = 1'b1;
        end
    end
    start    = (state == IDLE) && any;
    sel_rw   = pend[win] ? slot_rw[win]   : m_rw[win];
    sel_addr = pend[win] ? slot_addr[win] : m_addr[int'(win)*AW +: AW];
    sel_dtw  = pend[win] ? slot_dtw[win]  : m_dtw[int'(win)*DW +: DW];
  end

  // Completion and timeout are steered to the owner in the cycle they occur; ack beats timeout
  always_comb begin
    acking = (state == BUSY) && s_ack;
    tmo    = (TIMEOUT > 0) && (state == BUSY) && !s_ack && (cnt == CW'(TIMEOUT - 1));
    m_ack  = acking ? grant : '0;
    m_err  = tmo ? grant : '0;
    m_dtr  = acking ? s_dtr : '0;
    busy   = (state == BUSY);
    ram_ce = ~(s_stb | busy);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: one transaction at a time; the owner finishes on ack or timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = BUSY;
      BUSY:    if (acking || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Slave-side request, owner tracking and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      s_stb  <= 1'b0;
      s_rw   <= 1'b0;
      s_addr <= '0;
      s_dtw  <= '0;
      grant  <= '0;
      ptr    <= IW'(NM - 1);
      cnt    <= '0;
    end else begin
      s_stb <= 1'b0;
      if (start) begin
        s_stb  <= 1'b1;
        s_rw   <= sel_rw;
        s_addr <= sel_addr;
        s_dtw  <= sel_dtw;
        grant  <= NM'(1) << win;
        ptr    <= win;
        cnt    <= '0;
      end else if (state == BUSY) begin
        if (acking || tmo) grant <= '0;
        else               cnt   <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hs32_bus_arb.sv
// Scoreboard bench for hs32_bus_arb: a 4-master fixed-priority instance with
// timeout, and a 3-master round-robin instance without.
module tb_hs32_bus_arb;
  localparam int K_ACK = 0, K_ERR = 1, K_NONE = 2;

  typedef struct {
    int          m;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] dtw;
    int          kind;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_err = 0;

  // ---------------- instance A: NM=4, fixed priority, TIMEOUT=4
  logic         a_rst;
  logic [3:0]   a_stb, a_rw, a_ack, a_err, a_grant;
  logic [127:0] a_addr, a_dtw;
  logic [31:0]  a_dtr, a_saddr, a_sdtw, a_sdtr;
  logic         a_fen, a_sstb, a_srw, a_sack, a_busy, a_ce;
  logic [1:0]   a_fsel;
  assign a_sdtr = a_saddr ^ 32'h5A5A_0000;

  hs32_bus_arb #(.NM(4), .AW(32), .DW(32), .MODE(0), .TIMEOUT(4)) u_a (
    .clk(clk), .reset(a_rst), .m_stb(a_stb), .m_rw(a_rw), .m_addr(a_addr),
    .m_dtw(a_dtw), .m_ack(a_ack), .m_err(a_err), .m_dtr(a_dtr),
    .force_en(a_fen), .force_sel(a_fsel), .s_stb(a_sstb), .s_rw(a_srw),
    .s_addr(a_saddr), .s_dtw(a_sdtw), .s_dtr(a_sdtr), .s_ack(a_sack),
    .grant(a_grant), .busy(a_busy), .ram_ce(a_ce));

  // ---------------- instance B: NM=3, round-robin, no timeout
  logic         b_rst;
  logic [2:0]   b_stb, b_rw, b_ack, b_err, b_grant;
  logic [95:0]  b_addr, b_dtw;
  logic [31:0]  b_dtr, b_saddr, b_sdtw;
  logic         b_fen, b_sstb, b_srw, b_sack, b_busy, b_ce;
  logic [1:0]   b_fsel;

  hs32_bus_arb #(.NM(3), .AW(32), .DW(32), .MODE(1), .TIMEOUT(0)) u_b (
    .clk(clk), .reset(b_rst), .m_stb(b_stb), .m_rw(b_rw), .m_addr(b_addr),
    .m_dtw(b_dtw), .m_ack(b_ack), .m_err(b_err), .m_dtr(b_dtr),
    .force_en(b_fen), .force_sel(b_fsel), .s_stb(b_sstb), .s_rw(b_srw),
    .s_addr(b_saddr), .s_dtw(b_sdtw), .s_dtr(b_saddr), .s_ack(b_sack),
    .grant(b_grant), .busy(b_busy), .ram_ce(b_ce));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard A
  req_t a_q[$];
  req_t a_e, a_out;
  bit   a_out_v = 0;
  int   a_nstb = 0, a_last = -10;

  task automatic exp_push(input int m, input bit rw, input logic [31:0] ad,
                          input logic [31:0] dt, input int kind);
    req_t e;
    e.m = m; e.rw = rw; e.addr = ad; e.dtw = dt; e.kind = kind;
    a_q.push_back(e);
  endtask

  task automatic set_a(input int m, input bit rw, input logic [31:0] ad, input logic [31:0] dt);
    a_rw[m] = rw;
    a_addr[m*32 +: 32] = ad;
    a_dtw[m*32 +: 32] = dt;
    a_stb[m] = 1'b1;
  endtask

  task automatic wait_q(input int sz, input int lim, input string tag);
    int k;
    k = 0;
    while (!(a_q.size() == sz && !a_out_v) && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 64'(k < lim), 1);
  endtask

  // A monitor: match each slave request and each response against the scoreboard
  always @(negedge clk) begin
    if (a_rst) begin
      a_out_v = 0;
    end else begin
      if (a_sstb) begin
        a_nstb++;
        chk("a_gap", 64'((cyc - a_last) >= 2), 1);
        a_last = cyc;
        if (a_q.size() == 0) chk("a_unexp_stb", 1, 0);
        else begin
          a_e = a_q.pop_front();
          chk("a_grant", a_grant, 64'(1) << a_e.m);
          chk("a_srw", a_srw, a_e.rw);
          chk("a_saddr", a_saddr, a_e.addr);
          chk("a_sdtw", a_sdtw, a_e.dtw);
          chk("a_ce_stb", a_ce, 0);
          a_out = a_e;
          a_out_v = 1;
        end
      end
      if ((a_ack | a_err) != 0) begin
        chk("a_resp_1hot", $countones({a_ack, a_err}), 1);
        if (!a_out_v) chk("a_unexp_resp", {a_ack, a_err}, 0);
        else begin
          chk("a_ack", a_ack, (a_out.kind == K_ACK) ? (64'(1) << a_out.m) : 64'd0);
          chk("a_err", a_err, (a_out.kind == K_ERR) ? (64'(1) << a_out.m) : 64'd0);
          if (a_out.kind == K_ACK) chk("a_dtr", a_dtr, a_out.addr ^ 32'h5A5A_0000);
          a_out_v = 0;
        end
      end
    end
  end

  // A slave: ack sa_dly cycles after the strobe cycle (-1 = never), plus a manual ack
  int sa_dly = -1, sa_cnt = -1;
  bit sa_force = 0;
  initial begin
    a_sack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      a_sack = sa_force;
      if (a_rst) sa_cnt = -1;
      else begin
        if (a_sstb) sa_cnt = sa_dly;
        if (sa_cnt == 0) begin
          a_sack = 1'b1;
          sa_cnt = -1;
        end else if (sa_cnt > 0) sa_cnt--;
      end
    end
  end

  // ---------------- scoreboard B: expected grant order
  int b_q[$];
  int b_own = 0;
  bit b_sp = 0;
  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_sstb) begin
        if (b_q.size() == 0) chk("b_unexp_stb", 1, 0);
        else begin
          b_own = b_q.pop_front();
          chk("b_grant", b_grant, 64'(1) << b_own);
        end
      end
      if (b_ack != 0) chk("b_ack", b_ack, 64'(1) << b_own);
      if (b_err != 0) chk("b_err", b_err, 0);
    end
  end

  // B slave: ack one cycle after each strobe
  initial begin
    b_sack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      b_sack = b_sp;
      b_sp = b_sstb;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r0, r2;
    logic [2:0] nxt;
    a_rst = 1; b_rst = 1;
    a_stb = '0; a_rw = '0; a_addr = '0; a_dtw = '0; a_fen = 0; a_fsel = '0;
    b_stb = '0; b_rw = '0; b_dtw = '0; b_fen = 0; b_fsel = '0;
    b_addr = {32'h300, 32'h200, 32'h100};
    repeat (3) tick();

    // reset state
    @(negedge clk);
    chk("rst_ack", a_ack, 0);
    chk("rst_err", a_err, 0);
    chk("rst_dtr", a_dtr, 0);
    chk("rst_sstb", a_sstb, 0);
    chk("rst_srw", a_srw, 0);
    chk("rst_saddr", a_saddr, 0);
    chk("rst_sdtw", a_sdtw, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ce", a_ce, 1);
    tick();
    a_rst = 0; b_rst = 0;
    tick();

    // T1: single write from master 1, latency and ack timing
    sa_dly = 2;
    exp_push(1, 1, 32'h10, 32'hDEAD_BEEF, K_ACK);
    set_a(1, 1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_no_early_stb", a_sstb, 0);
    tick();
    a_stb = '0;
    @(negedge clk);
    chk("t1_sstb", a_sstb, 1);
    chk("t1_saddr", a_saddr, 32'h10);
    chk("t1_sdtw", a_sdtw, 32'hDEAD_BEEF);
    chk("t1_srw", a_srw, 1);
    chk("t1_ce", a_ce, 0);
    chk("t1_busy", a_busy, 1);
    @(negedge clk);
    chk("t1_stb_pulse", a_sstb, 0);
    chk("t1_hold_addr", a_saddr, 32'h10);
    chk("t1_no_ack_yet", a_ack, 0);
    @(negedge clk);
    chk("t1_ack", a_ack, 4'b0010);
    chk("t1_dtr", a_dtr, 32'h5A5A_0010);
    @(negedge clk);
    chk("t1_idle_busy", a_busy, 0);
    chk("t1_idle_grant", a_grant, 0);
    chk("t1_idle_ce", a_ce, 1);
    tick();

    // T2: all four masters at once, same-cycle acks, served 0..3
    sa_dly = 0;
    for (int m = 0; m < 4; m++) begin
      set_a(m, (m % 2) == 1, 32'h100 + 32'(m * 4), 32'hA0 + 32'(m));
      exp_push(m, (m % 2) == 1, 32'h100 + 32'(m * 4), 32'hA0 + 32'(m), K_ACK);
    end
    tick();
    a_stb = '0;
    wait_q(0, 40, "t2_done");

    // T3: force master 1; master 0 waits with its original request
    sa_dly = 1;
    a_fen = 1; a_fsel = 2'd1;
    exp_push(1, 1, 32'h300, 32'h1111_2222, K_ACK);
    exp_push(0, 0, 32'h200, 32'h0BAD_F00D, K_ACK);
    set_a(0, 0, 32'h200, 32'h0BAD_F00D);
    set_a(1, 1, 32'h300, 32'h1111_2222);
    tick();
    a_stb = '0;
    a_addr[31:0] = 32'hBAD0_BAD0;
    a_dtw[31:0] = 32'h0;
    wait_q(1, 20, "t3_forced_done");
    n = a_nstb;
    repeat (5) tick();
    chk("t3_hold_off", a_nstb, n);
    a_fen = 0;
    wait_q(0, 20, "t3_release_done");

    // T4: timeout on the 4th busy cycle, late ack ignored, ack on the 4th cycle wins
    sa_dly = -1;
    exp_push(0, 0, 32'h40, 32'h0, K_ERR);
    set_a(0, 0, 32'h40, 32'h0);
    tick();
    a_stb = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t4_no_err_c3", a_err, 0);
    @(negedge clk);
    chk("t4_err", a_err, 4'b0001);
    chk("t4_err_noack", a_ack, 0);
    tick();
    sa_force = 1;
    @(negedge clk);
    chk("t4_late_busy", a_busy, 0);
    chk("t4_late_ack", a_ack, 0);
    tick();
    sa_force = 0;
    sa_dly = 3;
    exp_push(0, 0, 32'h44, 32'h0, K_ACK);
    set_a(0, 0, 32'h44, 32'h0);
    tick();
    a_stb = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t4_ack_c4", a_ack, 4'b0001);
    chk("t4_ack_c4_noerr", a_err, 0);
    wait_q(0, 10, "t4_done");

    // T5: reset while busy with master 1 pending
    sa_dly = -1;
    exp_push(0, 1, 32'h80, 32'h5555, K_NONE);
    set_a(0, 1, 32'h80, 32'h5555);
    tick();
    a_stb = '0;
    set_a(1, 0, 32'h90, 32'h0);
    tick();
    a_stb = '0;
    a_rst = 1;
    tick();
    a_rst = 0;
    @(negedge clk);
    chk("t5_grant", a_grant, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_ce", a_ce, 1);
    n = a_nstb;
    repeat (8) tick();
    chk("t5_no_stb", a_nstb, n);
    sa_dly = 1;
    exp_push(2, 1, 32'hC0, 32'h77, K_ACK);
    set_a(2, 1, 32'hC0, 32'h77);
    tick();
    a_stb = '0;
    wait_q(0, 10, "t5_fresh_done");
    chk("a_outstanding", a_out_v, 0);

    // T6: round-robin, masters 0 and 2 re-request after each ack
    for (int k = 0; k < 4; k++) begin
      b_q.push_back(0);
      b_q.push_back(2);
    end
    b_stb = 3'b101;
    tick();
    b_stb = '0;
    r0 = 1; r2 = 1;
    for (int c = 0; c < 60 && (b_q.size() != 0 || b_busy); c++) begin
      @(negedge clk);
      nxt = '0;
      if (b_ack[0] && r0 < 4) begin nxt[0] = 1'b1; r0++; end
      if (b_ack[2] && r2 < 4) begin nxt[2] = 1'b1; r2++; end
      tick();
      b_stb = nxt;
    end
    b_stb = '0;
    repeat (3) tick();
    chk("b_all_served", b_q.size(), 0);
    chk("b_idle", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
